// File: rtl/cache_write_merge_ctrl.sv
// cache_write_merge_ctrl: write-combining buffer merging stores into one 128-bit line and draining it over valid/ready
module cache_write_merge_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_req,
  input  logic [3:0]        p_w_en,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [31:0]       write_data,
  output logic              p_stall,
  input  logic              flush_req,
  output logic              buf_busy,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_conflict,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [127:0]      wb_data,
  output logic [15:0]       wb_strb
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {EMPTY, MERGE, DRAIN} state_t;
  state_t state;
  logic [127:0]      line_q, md;
  logic [15:0]       strb_q, ps, ms;
  logic [ADDR_W-5:0] tag_q;
  logic [TW-1:0]     timer;
  logic              st_v, tag_hit, timeout;
  logic              unused_bits;
  assign unused_bits = ^{p_addr[1:0], rd_addr[3:0]};
  assign st_v    = p_req && (p_w_en != 4'b0);
  assign tag_hit = p_addr[ADDR_W-1:4] == tag_q;
  assign timeout = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));
  assign ps      = st_v ? (16'(p_w_en) << {p_addr[3:2], 2'b00}) : 16'h0;
  assign ms      = strb_q | ps;
  for (genvar b = 0; b < 16; b++) begin : g_lane
    assign md[8*b +: 8] = ps[b] ? write_data[8*(b%4) +: 8] : line_q[8*b +: 8];
  end
  assign p_stall     = st_v && (state == DRAIN || (state == MERGE && !tag_hit));
  assign buf_busy    = state != EMPTY;
  assign rd_conflict = (state != EMPTY) && (rd_addr[ADDR_W-1:4] == tag_q);
  assign wb_addr     = {tag_q, 4'b0};
  assign wb_data     = line_q;
  assign wb_strb     = strb_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      line_q   <= '0;
      strb_q   <= '0;
      tag_q    <= '0;
      timer    <= '0;
      wb_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (st_v) begin
          tag_q  <= p_addr[ADDR_W-1:4];
          line_q <= md;
          strb_q <= ms;
          timer  <= '0;
          state    <= (flush_req || ms == 16'hFFFF) ? DRAIN : MERGE;
          wb_valid <= flush_req || ms == 16'hFFFF;
        end
        MERGE: if (st_v && !tag_hit) begin
          state    <= DRAIN;
          wb_valid <= 1'b1;
        end else begin
          if (st_v) begin
            line_q <= md;
            strb_q <= ms;
            timer  <= '0;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
          // a same-cycle store is merged above before the drain is launched
          if (flush_req || ms == 16'hFFFF || (!st_v && timeout)) begin
            state    <= DRAIN;
            wb_valid <= 1'b1;
          end
        end
        default: if (wb_ready) begin
          line_q   <= '0;
          strb_q   <= '0;
          timer    <= '0;
          wb_valid <= 1'b0;
          state    <= EMPTY;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_write_merge_ctrl.sv
// tb_cache_write_merge_ctrl: scoreboard bench for the write-combining buffer
module tb_cache_write_merge_ctrl;
  logic         clk = 0, rst = 1;
  logic         p_req = 0, flush_req = 0, wb_ready = 0;
  logic [3:0]   p_w_en = 0;
  logic [31:0]  p_addr = 0, rd_addr = 0, write_data = 0;
  logic         p_stall, buf_busy, rd_conflict, wb_valid;
  logic [31:0]  wb_addr;
  logic [127:0] wb_data;
  logic [15:0]  wb_strb;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] a; logic [127:0] d; logic [15:0] s;} exp_t;
  exp_t q[$];

  cache_write_merge_ctrl #(.ADDR_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .p_req(p_req), .p_w_en(p_w_en), .p_addr(p_addr),
    .write_data(write_data), .p_stall(p_stall), .flush_req(flush_req),
    .buf_busy(buf_busy), .rd_addr(rd_addr), .rd_conflict(rd_conflict),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_strb(wb_strb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    p_req = 1; p_addr = a; p_w_en = w; write_data = d;
  endtask

  task automatic idle();
    p_req = 0; p_w_en = 0; flush_req = 0;
  endtask

  task automatic expect_wb(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s);
    exp_t e;
    e.a = a; e.d = d; e.s = s;
    q.push_back(e);
  endtask

  task automatic drain();
    wb_ready = 1;
    cyc();
    wb_ready = 0;
    #1;
    chk("drained_valid", 128'(wb_valid), 0);
    chk("drained_busy", 128'(buf_busy), 0);
  endtask

  always @(negedge clk) begin
    if (wb_valid && wb_ready) begin
      chk("sb_nonempty", 128'(q.size() != 0), 1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("wb_addr", 128'(wb_addr), 128'(e.a));
        chk("wb_data", wb_data, e.d);
        chk("wb_strb", 128'(wb_strb), 128'(e.s));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    #2;
    chk("rst_valid", 128'(wb_valid), 0);
    chk("rst_stall", 128'(p_stall), 0);
    chk("rst_busy", 128'(buf_busy), 0);
    chk("rst_conflict", 128'(rd_conflict), 0);
    cyc(); cyc();
    rst = 0;
    // zero mask is ignored
    store(32'h80, 4'h0, 32'h1);
    cyc();
    #1 chk("zero_mask_busy", 128'(buf_busy), 0);
    // idle timeout
    expect_wb(32'h100, 128'h0000CCDD << 32, 16'h0030);
    store(32'h104, 4'b0011, 32'hAABBCCDD);
    #1 chk("t1_stall", 128'(p_stall), 0);
    cyc();
    idle();
    n = 0;
    while (!wb_valid && n < 40) begin cyc(); n++; end
    chk("t1_timeout_latency", 128'(n), 16);
    drain();
    // full line from four word stores
    expect_wb(32'h200, 128'h00000004_00000003_00000002_00000001, 16'hFFFF);
    for (int k = 0; k < 4; k++) begin
      store(32'h200 + 32'(4 * k), 4'hF, 32'(k + 1));
      #1 chk("t2_stall", 128'(p_stall), 0);
      cyc();
    end
    idle();
    #1 chk("t2_valid", 128'(wb_valid), 1);
    drain();
    // byte merge over an existing word
    expect_wb(32'h300, 128'h11221111, 16'h000F);
    store(32'h300, 4'hF, 32'h11111111);
    cyc();
    store(32'h300, 4'b0100, 32'h00220000);
    cyc();
    idle();
    flush_req = 1;
    cyc();
    flush_req = 0;
    #1 chk("t3_valid", 128'(wb_valid), 1);
    drain();
    // line change with back-pressure
    expect_wb(32'h400, 128'hDEADBEEF, 16'h000F);
    expect_wb(32'h500, 128'h55, 16'h000F);
    store(32'h400, 4'hF, 32'hDEADBEEF);
    cyc();
    store(32'h500, 4'hF, 32'h55);
    #1 chk("t4_mismatch_stall", 128'(p_stall), 1);
    cyc();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_stall_low", 128'(p_stall), 1);
      chk("t4_valid_low", 128'(wb_valid), 1);
      chk("t4_addr_stable", 128'(wb_addr), 128'h400);
      cyc();
    end
    wb_ready = 1;
    #1 chk("t4_stall_hs", 128'(p_stall), 1);
    cyc();
    wb_ready = 0;
    #1 chk("t4_accept_stall", 128'(p_stall), 0);
    cyc();
    idle();
    rd_addr = 32'h508;
    #1;
    chk("t4_busy", 128'(buf_busy), 1);
    chk("t4_conflict", 128'(rd_conflict), 1);
    flush_req = 1;
    cyc();
    flush_req = 0;
    drain();
    // flush with store in EMPTY
    expect_wb(32'h600, 128'h77, 16'h0001);
    store(32'h600, 4'h1, 32'h77);
    flush_req = 1;
    cyc();
    idle();
    rd_addr = 32'h60C;
    #1;
    chk("t5_valid", 128'(wb_valid), 1);
    chk("t5_conflict", 128'(rd_conflict), 1);
    store(32'h600, 4'h0, 32'h0);
    #1 chk("t5_zero_mask_nostall", 128'(p_stall), 0);
    idle();
    cyc();
    #1 chk("t5_conflict_hold", 128'(rd_conflict), 1);
    drain();
    chk("t5_conflict_clear", 128'(rd_conflict), 0);
    flush_req = 1;
    cyc();
    flush_req = 0;
    cyc();
    #1;
    chk("t5_flush_only_valid", 128'(wb_valid), 0);
    chk("t5_flush_only_busy", 128'(buf_busy), 0);
    // async reset during drain
    store(32'h700, 4'hF, 32'h1);
    flush_req = 1;
    cyc();
    idle();
    rd_addr = 32'h700;
    #1 chk("t6_valid", 128'(wb_valid), 1);
    rst = 1;
    #1;
    chk("t6_rst_valid", 128'(wb_valid), 0);
    chk("t6_rst_busy", 128'(buf_busy), 0);
    chk("t6_rst_conflict", 128'(rd_conflict), 0);
    rst = 0;
    cyc();
    expect_wb(32'h900, 128'hCAFE0000 << 64, 16'h0F00);
    store(32'h908, 4'hF, 32'hCAFE0000);
    #1 chk("t6_post_stall", 128'(p_stall), 0);
    cyc();
    idle();
    #1 chk("t6_post_busy", 128'(buf_busy), 1);
    flush_req = 1;
    cyc();
    flush_req = 0;
    drain();
    cyc();
    chk("sb_leftover", 128'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_write_merge_ctrl.md
Name: cache_write_merge_ctrl

Overview:
Write-combining controller between the processor store port and the cache/memory write path. It places each processor store into a 128-bit line image with a 16-bit byte strobe, and merges successive stores to the same line into a single buffered line. It drains that line downstream over a valid/ready handshake. Drain triggers are: full line, line change, idle timeout or explicit flush.

Parameters:
ADDR_W, 32, byte address width; line tag is ADDR_W-1:4
TIMEOUT, 16, idle cycles in MERGE before auto-drain; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
p_req  in  1  processor store request
p_w_en  in  4  byte write mask for write_data
p_addr  in  ADDR_W  store byte address; [3:2] selects word in line
write_data  in  32  store data
p_stall  out  1  store not accepted this cycle; processor holds request
flush_req  in  1  force drain of buffered line
buf_busy  out  1  buffer holds data or is draining (state != EMPTY)
rd_addr  in  ADDR_W  pending read address from cache read path
rd_conflict  out  1  rd_addr line matches buffered line
wb_valid  out  1  drain request valid
wb_ready  in  1  downstream accepts drain
wb_addr  out  ADDR_W  line-aligned address {tag, 4'b0}
wb_data  out  128  merged line data; unwritten bytes 0
wb_strb  out  16  merged byte strobe

Behaviour:
- Reset (async, immediate): state=EMPTY; line buffer=0; strobe=0; tag=0; timer=0; wb_valid=0; p_stall=0; buf_busy=0; rd_conflict=0.
- Store "accepted" means p_req=1, p_w_en!=0 and p_stall=0 at a rising edge. p_req with p_w_en=0 is ignored and never stalls.
- Placement: word w=p_addr[3:2]. Byte lanes 4w..4w+3 carry write_data bytes masked by p_w_en. Strobe bits 4w..4w+3 = p_w_en. Other lanes 0.
- Merge rule: for each byte whose new strobe bit is 1, the byte is overwritten and its strobe set. Other bytes and strobes are unchanged (strobe accumulates by OR).
- States: EMPTY, MERGE, DRAIN.
- EMPTY: on accepted store, capture tag=p_addr[ADDR_W-1:4] and the placed data/strobe, clear timer. Go to MERGE, or to DRAIN if flush_req=1 the same cycle or the strobe is 16'hFFFF. flush_req alone has no effect.
- MERGE, same-tag store: merged and timer cleared.
- MERGE, different-tag store: p_stall=1 combinationally in that cycle; store not taken; go to DRAIN. The store is accepted in EMPTY after the drain completes.
- MERGE, full line: if the merged strobe equals 16'hFFFF, go to DRAIN next cycle.
- MERGE, flush_req=1: go to DRAIN. A same-cycle same-tag store is merged first and included in the drain.
- MERGE, timeout: timer increments each cycle without an accepted store. When TIMEOUT!=0 and timer reaches TIMEOUT-1, go to DRAIN.
- DRAIN: wb_valid=1 (registered). wb_addr/wb_data/wb_strb are held stable until wb_valid&&wb_ready. On handshake: buffer, strobe and timer cleared; go to EMPTY. p_stall=1 for any valid store throughout DRAIN, including the handshake cycle. flush_req is ignored.
- Drain latency: wb_valid rises the cycle after the trigger edge. Minimum store-to-wb_valid is 1 cycle for full-line or flush.
- p_stall = (state==DRAIN && p_req && p_w_en!=0) || (state==MERGE && p_req && p_w_en!=0 && tag mismatch). This term is purely combinational.
- rd_conflict = (state!=EMPTY) && rd_addr[ADDR_W-1:4]==tag, combinational. The read path must stall or forward while it is high.
- Timer width is clog2(TIMEOUT)+1. The timer saturates and never wraps.
- Reset asserted mid-DRAIN drops wb_valid immediately; buffered data is lost by definition.

Test Plan:
- Single store p_addr=0x104, p_w_en=4'b0011, data=0xAABBCCDD, then idle with TIMEOUT=16 -> after 16 idle cycles wb_valid=1; wb_addr=0x100; wb_strb=16'h0030; wb_data[63:32]=0x0000CCDD; rest 0.
- Four full-word stores to 0x200, 0x204, 0x208, 0x20C with data 1,2,3,4 on consecutive cycles -> no stall; wb_valid one cycle after the 4th; wb_strb=16'hFFFF; wb_data=0x00000004_00000003_00000002_00000001.
- Store 0x300 w_en=4'hF data=0x11111111, then store 0x300 w_en=4'b0100 data=0x00220000 -> drained word0=0x11221111, wb_strb=16'h000F.
- Buffered line at 0x400; store to 0x500 with wb_ready held low 3 cycles -> p_stall=1 for all 4 cycles (3 low, plus the handshake cycle); wb_addr=0x400 stable; after handshake the 0x500 store is accepted and buf_busy stays 1.
- flush_req together with store 0x600 w_en=4'h1 in EMPTY -> wb_valid next cycle, wb_strb=16'h0001. rd_addr=0x60C gives rd_conflict=1 until handshake. flush_req in EMPTY with no store leaves wb_valid=0.
- Assert rst during DRAIN with wb_ready=0 -> wb_valid, buf_busy and rd_conflict go 0 without a clock edge; the next store to any address is accepted without stall.
